// File: rtl/config_seq_pkg.sv
// Shared types and constants for the configuration bitstream sequencer.
package config_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_DONE = 3'd2,
    DONE      = 3'd3,
    ERROR     = 3'd4
  } seq_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Each stage takes 2^lutsize writes.
  function automatic int calc_total(input int lutsize, input int stages);
    return stages << lutsize;
  endfunction

endpackage

// File: rtl/config_seq_crc16.sv
// CRC-16-CCITT accumulator: one WIDTH-bit word per enabled cycle, fed MSB-first.
module config_seq_crc16
  import config_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [15:0]      crc
);

  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [WIDTH-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ CRC_POLY;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || clear) crc <= CRC_INIT;
    else if (enable)    crc <= crc_next(crc, data);
  end

endmodule

// File: rtl/config_bitstream_sequencer.sv
// Streams configuration words from a valid/ready source into the configuration
// controller, then waits for its done. CONFIG_SEQ_CRC_EN adds a CRC-16 trailer check.
//   state     | meaning
//   IDLE      | after reset, waiting for start
//   LOAD      | accepting words, one controller write per data word
//   WAIT_DONE | all writes issued, timing cfg_done
//   DONE      | controller reported done
//   ERROR     | abort, early done, timeout or CRC mismatch
`ifndef ZUMA_LUT_SIZE
`define ZUMA_LUT_SIZE 2
`endif
`ifndef NUM_CONFIG_STAGES
`define NUM_CONFIG_STAGES 3
`endif
`ifndef CONFIG_WIDTH
`define CONFIG_WIDTH 32
`endif

module config_bitstream_sequencer
  import config_seq_pkg::*;
#(
  parameter int LUTSIZE      = `ZUMA_LUT_SIZE,
  parameter int STAGES       = `NUM_CONFIG_STAGES,
  parameter int WIDTH        = `CONFIG_WIDTH,
  parameter int DONE_TIMEOUT = 64,
  parameter int CNT_W        = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             cfg_wren,
  output logic [31:0]      cfg_addr,
  output logic [WIDTH-1:0] cfg_data,
  input  logic             cfg_done,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_written
`ifdef CONFIG_SEQ_CRC_EN
  ,
  output logic             crc_fail
`endif
);

  localparam int                 TOTAL    = calc_total(LUTSIZE, STAGES);
  localparam logic [CNT_W-1:0]   TOTAL_C  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]   LAST_C   = CNT_W'(TOTAL - 1);
  localparam int                 TMR_W    = $clog2(DONE_TIMEOUT);
  localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(DONE_TIMEOUT - 1);

  seq_state_t       state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic             first_wr;
  logic             data_left;
  logic             start_ok;
  logic             accept_data;
`ifdef CONFIG_SEQ_CRC_EN
  logic [15:0]      crc;
  logic             crc_bad;
`endif

  assign data_left = words_written < TOTAL_C;
  // abort masks a simultaneous start; start is only honoured outside a load
  assign start_ok  = start && !abort && (state == IDLE || state == DONE || state == ERROR);

  assign busy  = (state == LOAD) || (state == WAIT_DONE);
  assign done  = (state == DONE);
  assign error = (state == ERROR);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    accept_data = 1'b0;
`ifdef CONFIG_SEQ_CRC_EN
    crc_bad     = 1'b0;
`endif
    case (state)
      IDLE, DONE, ERROR: begin
        if (start_ok) state_nxt = LOAD;
      end
      LOAD: begin
        // abort and early done both refuse the word offered this cycle
        if (abort || cfg_done) begin
          state_nxt = ERROR;
        end else begin
`ifdef CONFIG_SEQ_CRC_EN
          s_ready = 1'b1;
`else
          s_ready = data_left;
`endif
          if (s_valid && s_ready) begin
            if (data_left) begin
              accept_data = 1'b1;
`ifndef CONFIG_SEQ_CRC_EN
              if (words_written == LAST_C) state_nxt = WAIT_DONE;
`endif
            end
`ifdef CONFIG_SEQ_CRC_EN
            else if (s_data[15:0] != crc) begin
              crc_bad   = 1'b1;
              state_nxt = ERROR;
            end else begin
              state_nxt = WAIT_DONE;
            end
`endif
          end
        end
      end
      WAIT_DONE: begin
        if (abort)               state_nxt = ERROR;
        else if (cfg_done)       state_nxt = DONE;
        else if (timer == '0)    state_nxt = ERROR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer         <= '0;
      words_written <= '0;
      first_wr      <= 1'b0;
      cfg_wren      <= 1'b0;
      cfg_addr      <= '0;
      cfg_data      <= '0;
    end else begin
      cfg_wren <= accept_data;
      cfg_addr <= (accept_data && first_wr) ? 32'd1 : 32'd0;
      if (accept_data) cfg_data <= s_data;

      if (start_ok) begin
        words_written <= '0;
        first_wr      <= 1'b1;
      end else if (accept_data) begin
        words_written <= words_written + 1'b1;
        first_wr      <= 1'b0;
      end

      // timer counts down through WAIT_DONE; zero in WAIT_DONE is the last allowed cycle
      if (state_nxt == WAIT_DONE && state != WAIT_DONE) timer <= TMR_LOAD;
      else if (state == WAIT_DONE && timer != '0)       timer <= timer - 1'b1;
    end
  end

`ifdef CONFIG_SEQ_CRC_EN
  config_seq_crc16 #(
    .WIDTH(WIDTH)
  ) u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_ok),
    .enable (accept_data),
    .data   (s_data),
    .crc    (crc)
  );

  always_ff @(posedge clk) begin
    if (reset)         crc_fail <= 1'b0;
    else if (start_ok) crc_fail <= 1'b0;
    else if (crc_bad)  crc_fail <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_config_bitstream_sequencer.sv
// Self-checking bench for config_bitstream_sequencer: vector table, random loads, reset corner.
module tb_config_bitstream_sequencer;

  localparam int LUTSIZE      = 2;
  localparam int STAGES       = 3;
  localparam int WIDTH        = 32;
  localparam int DONE_TIMEOUT = 16;
  localparam int CNT_W        = 20;
  localparam int TOTAL        = STAGES * (2 ** LUTSIZE);
`ifdef CONFIG_SEQ_CRC_EN
  localparam int NW = TOTAL + 1;
`else
  localparam int NW = TOTAL;
`endif

  logic             clk = 1'b0;
  logic             reset, start, abort, s_valid, cfg_done;
  logic [WIDTH-1:0] s_data;
  logic             s_ready, cfg_wren, busy, done, error;
  logic [31:0]      cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic [CNT_W-1:0] words_written;
`ifdef CONFIG_SEQ_CRC_EN
  logic             crc_fail;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  config_bitstream_sequencer #(
    .LUTSIZE(LUTSIZE), .STAGES(STAGES), .WIDTH(WIDTH),
    .DONE_TIMEOUT(DONE_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_wren(cfg_wren), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_done(cfg_done), .busy(busy), .done(done), .error(error),
    .words_written(words_written)
`ifdef CONFIG_SEQ_CRC_EN
    , .crc_fail(crc_fail)
`endif
  );

  typedef struct {
    string name;
    int    mode;        // 0 continuous, 1 every other cycle, 2 random
    int    done_delay;  // wait-cycles before cfg_done; -1 never
    int    early_at;    // cfg_done while this many words accepted; -1 never
    int    abort_at;    // abort while offering this word index; -1 never
    int    restart_at;  // start pulse during load at this index; -1 never
    bit    corrupt;     // flip bit 0 of the CRC trailer
    bit    exp_done;
    int    exp_writes;
    bit    timeout;
  } vec_t;

  vec_t vecs[$];
  logic [WIDTH-1:0] words [NW];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input int mode, input int dd, input int ea,
                              input int ab, input int rs, input bit cor, input bit ed,
                              input int ew, input bit to);
    vec_t v;
    v.name = name; v.mode = mode; v.done_delay = dd; v.early_at = ea; v.abort_at = ab;
    v.restart_at = rs; v.corrupt = cor; v.exp_done = ed; v.exp_writes = ew; v.timeout = to;
    return v;
  endfunction

  // Reference CRC: serialise all data words MSB-first into a bit list, then shift.
  function automatic logic [15:0] crc_ref();
    bit          bits[$];
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < TOTAL; k++)
      for (int b = WIDTH - 1; b >= 0; b--) bits.push_back(words[k][b]);
    foreach (bits[i]) c = (c[15] ^ bits[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic run_vec(input vec_t v);
    int idx = 0, wcnt = 0, cyc = 0, nwr = 0, extra = 0;
    int lat_err = 0, wr_err = 0, rdy_err = 0;
    bit prev_acc = 0, fin = 0, early_fired = 0, restart_fired = 0;
    logic [31:0]      la[$];
    logic [WIDTH-1:0] ld[$];
    logic [31:0]      tmp;
    for (int k = 0; k < TOTAL; k++) words[k] = $urandom;
`ifdef CONFIG_SEQ_CRC_EN
    tmp = $urandom;
    words[TOTAL] = {tmp[31:16], crc_ref() ^ {15'd0, v.corrupt}};
`endif
    @(posedge clk); #1;
    s_valid = 0; cfg_done = 0; abort = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    check({v.name, "_start_ww"}, words_written, 0);
    check({v.name, "_start_busy"}, busy, 1);
    while (!fin && cyc < 600) begin
      s_valid = 0; cfg_done = 0; abort = 0; start = 0;
      if (idx < NW) begin
        case (v.mode)
          0:       s_valid = 1;
          1:       s_valid = cyc[0];
          default: s_valid = 1'($urandom_range(0, 1));
        endcase
        s_data = words[idx];
        if (v.abort_at >= 0 && idx == v.abort_at) begin s_valid = 1; abort = 1; end
        if (v.early_at >= 0 && idx == v.early_at && !early_fired) begin
          cfg_done = 1; early_fired = 1;
        end
        if (v.restart_at >= 0 && idx == v.restart_at && !restart_fired) begin
          start = 1; restart_fired = 1;
        end
      end else if (v.done_delay >= 0 && wcnt == v.done_delay) begin
        cfg_done = 1;
      end
      @(negedge clk);
      if (cfg_wren === 1'b1) begin nwr++; la.push_back(cfg_addr); ld.push_back(cfg_data); end
      if (cfg_wren !== prev_acc) lat_err++;
      if (idx == NW && s_ready === 1'b1) rdy_err++;
      if (abort && s_ready === 1'b1) rdy_err++;
      if (idx == NW && busy === 1'b1) wcnt++;
      prev_acc = s_valid && s_ready && (idx < TOTAL);
      if (s_valid && s_ready) idx++;
      if (done === 1'b1 || error === 1'b1) fin = 1;
      @(posedge clk); #1;
      cyc++;
    end
    check({v.name, "_finished"}, fin, 1);
    s_valid = 1; cfg_done = 0; abort = 0; start = 0;
    repeat (4) begin
      @(negedge clk);
      if (cfg_wren !== 1'b0) extra++;
    end
    s_valid = 0;
    for (int k = 0; k < la.size(); k++) begin
      if (la[k] !== ((k == 0) ? 32'd1 : 32'd0)) wr_err++;
      if (k >= TOTAL || ld[k] !== words[k]) wr_err++;
    end
    check({v.name, "_writes"}, nwr, v.exp_writes);
    check({v.name, "_wr_content"}, wr_err, 0);
    check({v.name, "_latency"}, lat_err, 0);
    check({v.name, "_ready"}, rdy_err, 0);
    check({v.name, "_extra_wr"}, extra, 0);
    check({v.name, "_done"}, done, v.exp_done);
    check({v.name, "_error"}, error, !v.exp_done);
    check({v.name, "_busy"}, busy, 0);
    check({v.name, "_ww"}, words_written, v.exp_writes);
    if (v.timeout) check({v.name, "_wait_cycles"}, wcnt, DONE_TIMEOUT);
`ifdef CONFIG_SEQ_CRC_EN
    check({v.name, "_crc_fail"}, crc_fail, v.corrupt);
    if (v.corrupt) check({v.name, "_no_wait"}, wcnt, 0);
`endif
  endtask

  task automatic reset_mid_load();
    int idx = 0, cyc = 0, bad = 0;
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0; s_valid = 1;
    while (idx < 4 && cyc < 50) begin
      s_data = $urandom;
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_reached_word4", idx, 4);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("rst_cfg_wren", cfg_wren, 0);
    check("rst_cfg_addr", cfg_addr, 0);
    check("rst_cfg_data", cfg_data, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_status", {busy, done, error}, 3'b000);
    check("rst_ww", words_written, 0);
    repeat (3) begin
      @(negedge clk);
      if (cfg_wren !== 1'b0 || s_ready !== 1'b0) bad++;
    end
    s_valid = 0;
    check("rst_idle_quiet", bad, 0);
  endtask

  initial begin
    reset = 1; start = 0; abort = 0; s_valid = 0; cfg_done = 0; s_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("reset_s_ready", s_ready, 0);
    check("reset_cfg_wren", cfg_wren, 0);
    check("reset_cfg_addr", cfg_addr, 0);
    check("reset_cfg_data", cfg_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_ww", words_written, 0);
`ifdef CONFIG_SEQ_CRC_EN
    check("reset_crc_fail", crc_fail, 0);
`endif

    //               name          mode dly              early abort rst cor done writes    to
    vecs.push_back(mk("cont",        0,  5,                -1, -1,  -1, 0, 1, TOTAL, 0));
    vecs.push_back(mk("alt",         1,  5,                -1, -1,  -1, 0, 1, TOTAL, 0));
    vecs.push_back(mk("timeout",     0, -1,                -1, -1,  -1, 0, 0, TOTAL, 1));
    vecs.push_back(mk("after_to",    0,  3,                -1, -1,  -1, 0, 1, TOTAL, 0));
    vecs.push_back(mk("early_done",  0, -1,                 5, -1,  -1, 0, 0, 5,     0));
    vecs.push_back(mk("abort7",      0, -1,                -1,  6,  -1, 0, 0, 6,     0));
    vecs.push_back(mk("start_in_ld", 1,  2,                -1, -1,   3, 0, 1, TOTAL, 0));
    vecs.push_back(mk("done_vs_to",  0, DONE_TIMEOUT - 1,  -1, -1,  -1, 0, 1, TOTAL, 0));
    vecs.push_back(mk("done_at_0",   2,  0,                -1, -1,  -1, 0, 1, TOTAL, 0));
`ifdef CONFIG_SEQ_CRC_EN
    vecs.push_back(mk("crc_bad",     0,  5,                -1, -1,  -1, 1, 0, TOTAL, 0));
    vecs.push_back(mk("crc_good",    2,  4,                -1, -1,  -1, 0, 1, TOTAL, 0));
`endif
    for (int r = 0; r < 4; r++)
      vecs.push_back(mk($sformatf("rand%0d", r), 2, $urandom_range(0, DONE_TIMEOUT - 1),
                        -1, -1, -1, 0, 1, TOTAL, 0));

    foreach (vecs[i]) run_vec(vecs[i]);

    reset_mid_load();
    run_vec(mk("post_reset", 0, 1, -1, -1, -1, 0, 1, TOTAL, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_bitstream_sequencer.md
Name: config_bitstream_sequencer

Overview:
- Streaming front-end that feeds configuration words from an off-chip/ROM source into the serial configuration controller.
- Accepts a valid/ready word stream and issues the start-of-config write, then all per-stage LUT writes.
- Waits for the controller's done, then reports status.
- Sits between the host/bitstream-ROM interface and the overlay's configuration controller, one instance per overlay.

Parameters:
- LUTSIZE, `ZUMA_LUT_SIZE, address bits per stage; each stage takes 2^LUTSIZE writes.
- STAGES, `NUM_CONFIG_STAGES, number of configuration stages (tiles).
- WIDTH, `CONFIG_WIDTH, configuration data word width.
- DONE_TIMEOUT, 64, maximum cycles to wait for cfg_done after the last write (≥2).
- CNT_W, 20, width of the word counter; must satisfy 2^CNT_W > STAGES*2^LUTSIZE.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load when IDLE, DONE or ERROR; ignored otherwise
- abort  in  1  stops an active load; block goes to ERROR
- s_data  in  WIDTH  stream word
- s_valid  in  1  stream word valid
- s_ready  out  1  block accepts s_data this cycle
- cfg_wren  out  1  write enable to the configuration controller
- cfg_addr  out  32  32'd1 on the first write of a load, 0 otherwise
- cfg_data  out  WIDTH  word written with cfg_wren
- cfg_done  in  1  done from the configuration controller shift chain
- busy  out  1  high in LOAD or WAIT_DONE
- done  out  1  high in DONE
- error  out  1  high in ERROR
- words_written  out  CNT_W  writes issued in the current/last load

Behaviour:
- Reset: state IDLE; s_ready=0, cfg_wren=0, cfg_addr=0, cfg_data=0, busy=0, done=0, error=0, words_written=0. Reset mid-load discards everything with no further cfg_wren.
- TOTAL = STAGES<<LUTSIZE, computed at elaboration.
- All cfg_* outputs are registered. A word accepted at edge N (s_valid&&s_ready) appears as cfg_wren=1 at cycle N+1. cfg_wren is never asserted two cycles with the same word.
- States:
  - IDLE: s_ready=0. start → LOAD, clears words_written.
  - LOAD: s_ready=1 while words_written < TOTAL. Each accepted word issues one write and increments words_written.
    - The first write of the load carries cfg_addr=32'd1; all later writes carry cfg_addr=0.
    - Gaps (s_valid=0) are legal and produce no write.
    - When the TOTAL-th word is accepted, s_ready drops the next cycle → WAIT_DONE.
  - WAIT_DONE: s_ready=0, timer runs.
    - cfg_done=1 → DONE.
    - Timer reaching DONE_TIMEOUT → ERROR.
    - cfg_done and timeout in the same cycle → DONE takes priority.
  - DONE: done=1, holds until start (→ LOAD) or reset.
  - ERROR: error=1, holds until start (→ LOAD) or reset.
- cfg_done=1 while in LOAD (early done) → ERROR next cycle; any pending write still completes.
- abort in LOAD or WAIT_DONE → ERROR next cycle; abort has priority over a simultaneous word acceptance (word not accepted, s_ready=0 that cycle). abort in IDLE, DONE or ERROR is ignored.
- start in LOAD or WAIT_DONE is ignored. start and abort together: abort wins.
- words_written saturates at TOTAL; it is never reset except by reset or a new start.

Optional Feature:
- Macro CONFIG_SEQ_CRC_EN.
- When defined:
  - After TOTAL data words, LOAD accepts one extra trailer word; its low 16 bits are the expected CRC-16-CCITT (poly 0x1021, init 0xFFFF) over all TOTAL words, each fed as WIDTH bits MSB-first.
  - The trailer is never written to the controller.
  - Mismatch → ERROR without entering WAIT_DONE. Match → WAIT_DONE.
  - Adds output crc_fail (1 bit, reset 0, set on mismatch, cleared on start).
- When not defined: no trailer, no crc_fail port, and no CRC logic.

Decomposition:
- Shared package config_seq_pkg:
  - state enum (IDLE, LOAD, WAIT_DONE, DONE, ERROR)
  - CRC_POLY=16'h1021, CRC_INIT=16'hFFFF
  - function computing TOTAL from LUTSIZE and STAGES
- One sub-module, config_seq_crc16: per-word CRC update with clear, enable, data inputs and crc output; instantiated only under CONFIG_SEQ_CRC_EN.

Test Plan:
- LUTSIZE=2, STAGES=3, continuous s_valid → 12 cfg_wren pulses. First pulse has cfg_addr=1, the rest 0. cfg_data matches stream order, 1-cycle latency. cfg_done driven 5 cycles later → done=1, words_written=12.
- Same config with s_valid toggling every other cycle → still exactly 12 writes, no duplicates. s_ready=0 after the 12th acceptance.
- No cfg_done after the last write → error=1 exactly DONE_TIMEOUT cycles after entering WAIT_DONE. Then start → new load, first write again cfg_addr=1.
- cfg_done pulsed after 5 writes → ERROR next cycle, no further cfg_wren. abort at word 7 with s_valid=1 → word 7 not accepted, error=1.
- reset asserted at word 4 → all outputs zero next cycle. start ignored during LOAD (words_written unaffected).
- CONFIG_SEQ_CRC_EN: correct trailer → DONE, 12 writes only. Corrupted trailer (bit 0 flipped) → ERROR with crc_fail=1, no WAIT_DONE.
